// File: rtl/csr_pkg.sv
// csr_pkg: shared types and constants for the CSR command sequencer slice.
package csr_pkg;

  localparam int unsigned ADDR_WIDTH  = 6;
  localparam int unsigned DATA_WIDTH  = 8;
  localparam int unsigned DEPTH       = 32;
  localparam int unsigned TIMEOUT_CYC = 255;

  // Command byte opcodes (upper two bits of the command byte)
  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_RD    = 2'b01,
    OP_WR    = 2'b10,
    OP_BURST = 2'b11
  } op_e;

  // Command byte layout: {op[1:0], addr[5:0]}
  typedef struct packed {
    op_e                   op;
    logic [ADDR_WIDTH-1:0] addr;
  } cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WDATA    = 3'd1,
    ST_RD_ISSUE = 3'd2,
    ST_RD_CAPT  = 3'd3,
    ST_RESP     = 3'd4
  } state_e;

  // Well-known CSR indices
  localparam logic [ADDR_WIDTH-1:0] CSR_CTRL   = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] CSR_PWM_HI = ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0] CSR_PWM_LO = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] CSR_PORTA  = ADDR_WIDTH'(27);

  // True when the address maps onto an implemented CSR entry
  function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] a);
    return (32'(a) < DEPTH);
  endfunction

  // Burst address step, wrapping from the last implemented entry back to 0
  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a);
    if (32'(a) >= (DEPTH - 1)) return '0;
    return a + ADDR_WIDTH'(1);
  endfunction

endpackage

// File: rtl/csr_cmd_sequencer_if.sv
// csr_cmd_sequencer_if: SPI byte stream and CSR strobe bus of the sequencer.
interface csr_cmd_sequencer_if;
  import csr_pkg::*;

  logic                  spi_cs_act;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_load;
  logic [ADDR_WIDTH-1:0] csr_addr;
  logic [DATA_WIDTH-1:0] csr_wdata;
  logic                  csr_we;
  logic                  csr_re;
  logic [DATA_WIDTH-1:0] csr_rdata;
  logic                  busy;
  logic                  err;

  // Sequencer side
  modport master (
    input  spi_cs_act, rx_data, rx_valid, csr_rdata,
    output tx_data, tx_load, csr_addr, csr_wdata, csr_we, csr_re, busy, err
  );

  // SPI slave / CSR file side
  modport slave (
    output spi_cs_act, rx_data, rx_valid, csr_rdata,
    input  tx_data, tx_load, csr_addr, csr_wdata, csr_we, csr_re, busy, err
  );

endinterface

// File: rtl/csr_seq_timeout.sv
// csr_seq_timeout: loadable down-counter; expired_c flags a count of zero.
module csr_seq_timeout
  import csr_pkg::*;
#(
  parameter int unsigned LOAD_VAL = TIMEOUT_CYC
) (
  input  logic clk,
  input  logic rst_bar,
  input  logic load,
  input  logic en,
  output logic expired_c
);

  localparam int unsigned CW = $clog2(LOAD_VAL + 1);

  logic [CW-1:0] cnt_q;

  // Load has priority; counting saturates at zero
  always_ff @(posedge clk or negedge rst_bar) begin
    if (!rst_bar)                 cnt_q <= '0;
    else if (load)                cnt_q <= CW'(LOAD_VAL);
    else if (en && cnt_q != '0)   cnt_q <= cnt_q - CW'(1);
  end

  assign expired_c = (cnt_q == '0);

endmodule

// File: rtl/csr_cmd_sequencer.sv
// csr_cmd_sequencer: parses SPI command bytes into single-cycle CSR strobes.
// Optional burst writes (op 11) are built when CSR_SEQ_BURST_EN is defined;
// otherwise op 11 is treated as a NOP.
module csr_cmd_sequencer
  import csr_pkg::*;
(
  input  logic                clk,
  input  logic                rst_bar,
  csr_cmd_sequencer_if.master bus
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  bad_q, bad_d;
  logic                  burst_q, burst_d;

  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  tx_load_q, tx_load_d;
  logic [ADDR_WIDTH-1:0] csr_addr_q, csr_addr_d;
  logic [DATA_WIDTH-1:0] csr_wdata_q, csr_wdata_d;
  logic                  csr_we_q, csr_we_d;
  logic                  csr_re_q, csr_re_d;
  logic                  busy_q;
  logic                  err_q, err_d;

  logic                  tmo_load;
  logic                  tmo_en;
  logic                  tmo_expired;
  cmd_t                  cmd;

  assign cmd    = cmd_t'(bus.rx_data);
  assign tmo_en = (state_q == ST_WDATA);

  // Inter-byte watchdog, active only while waiting for write data
  csr_seq_timeout #(.LOAD_VAL(TIMEOUT_CYC)) u_timeout (
    .clk       (clk),
    .rst_bar   (rst_bar),
    .load      (tmo_load),
    .en        (tmo_en),
    .expired_c (tmo_expired)
  );

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_bar) begin
    if (!rst_bar) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      bad_q       <= 1'b0;
      burst_q     <= 1'b0;
      tx_data_q   <= '0;
      tx_load_q   <= 1'b0;
      csr_addr_q  <= '0;
      csr_wdata_q <= '0;
      csr_we_q    <= 1'b0;
      csr_re_q    <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      bad_q       <= bad_d;
      burst_q     <= burst_d;
      tx_data_q   <= tx_data_d;
      tx_load_q   <= tx_load_d;
      csr_addr_q  <= csr_addr_d;
      csr_wdata_q <= csr_wdata_d;
      csr_we_q    <= csr_we_d;
      csr_re_q    <= csr_re_d;
      busy_q      <= (state_d != ST_IDLE);
      err_q       <= err_d;
    end
  end

  // Next-state and next-output decode; chip-select release overrides everything
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    bad_d       = bad_q;
    burst_d     = burst_q;
    tx_data_d   = tx_data_q;
    tx_load_d   = 1'b0;
    csr_addr_d  = csr_addr_q;
    csr_wdata_d = csr_wdata_q;
    csr_we_d    = 1'b0;
    csr_re_d    = 1'b0;
    err_d       = err_q;
    tmo_load    = 1'b0;

    if (!bus.spi_cs_act) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.rx_valid) begin
            addr_d  = cmd.addr;
            bad_d   = !addr_in_range(cmd.addr);
            burst_d = 1'b0;
            case (cmd.op)
              OP_RD: begin
                state_d    = ST_RD_ISSUE;
                csr_addr_d = cmd.addr;
                csr_re_d   = addr_in_range(cmd.addr);
                if (!addr_in_range(cmd.addr)) err_d = 1'b1;
              end
              OP_WR: begin
                state_d  = ST_WDATA;
                tmo_load = 1'b1;
                if (!addr_in_range(cmd.addr)) err_d = 1'b1;
              end
`ifdef CSR_SEQ_BURST_EN
              OP_BURST: begin
                state_d  = ST_WDATA;
                burst_d  = 1'b1;
                tmo_load = 1'b1;
                if (!addr_in_range(cmd.addr)) err_d = 1'b1;
              end
`endif
              default: err_d = 1'b0;
            endcase
          end
        end
        ST_WDATA: begin
          if (tmo_expired) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else if (bus.rx_valid) begin
            if (!bad_q) begin
              csr_we_d    = 1'b1;
              csr_addr_d  = addr_q;
              csr_wdata_d = bus.rx_data;
            end
            if (burst_q) begin
              addr_d   = next_addr(addr_q);
              tmo_load = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        ST_RD_ISSUE: state_d = ST_RD_CAPT;
        ST_RD_CAPT: begin
          tx_data_d = bad_q ? '0 : bus.csr_rdata;
          state_d   = ST_RESP;
        end
        ST_RESP: begin
          tx_load_d = 1'b1;
          state_d   = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign bus.tx_data   = tx_data_q;
  assign bus.tx_load   = tx_load_q;
  assign bus.csr_addr  = csr_addr_q;
  assign bus.csr_wdata = csr_wdata_q;
  assign bus.csr_we    = csr_we_q;
  assign bus.csr_re    = csr_re_q;
  assign bus.busy      = busy_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_csr_cmd_sequencer.sv
// tb_csr_cmd_sequencer: directed vectors and corner sequences for the sequencer.
module tb_csr_cmd_sequencer;
  import csr_pkg::*;

  typedef struct packed {
    logic                  busy;
    logic                  err;
    logic                  we;
    logic                  re;
    logic                  txl;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] txd;
  } obs_t;

  typedef struct {
    logic       cs;
    logic       rv;
    logic [7:0] rx;
    obs_t       exp;
  } vec_t;

  localparam int NVEC = 25;

  logic       clk = 1'b0;
  logic       rst_bar;
  logic [7:0] rdata_src;
  int         total = 0;
  int         bad = 0;
  int         we_cnt = 0;
  int         re_cnt = 0;
  int         overlap_cnt = 0;
  logic [5:0] wlog_addr [8];
  logic [7:0] wlog_data [8];

  always #5 clk = ~clk;

  csr_cmd_sequencer_if bus ();

  csr_cmd_sequencer dut (
    .clk     (clk),
    .rst_bar (rst_bar),
    .bus     (bus)
  );

  // CSR file stand-in with one cycle of read latency
  always @(posedge clk or negedge rst_bar) begin
    if (!rst_bar)        bus.csr_rdata <= '0;
    else if (bus.csr_re) bus.csr_rdata <= rdata_src;
  end

  // Strobe log
  always @(posedge clk) begin
    if (bus.csr_we) begin
      wlog_addr[we_cnt[2:0]] <= bus.csr_addr;
      wlog_data[we_cnt[2:0]] <= bus.csr_wdata;
      we_cnt <= we_cnt + 1;
    end
    if (bus.csr_re) re_cnt <= re_cnt + 1;
    if (bus.csr_we && bus.csr_re) overlap_cnt <= overlap_cnt + 1;
  end

  function automatic obs_t mk(input logic busy, err, we, re, txl,
                              input logic [5:0] addr, input logic [7:0] wdata, txd);
    obs_t o;
    o.busy = busy; o.err = err; o.we = we; o.re = re; o.txl = txl;
    o.addr = addr; o.wdata = wdata; o.txd = txd;
    return o;
  endfunction

  function automatic vec_t v(input logic cs, rv, input logic [7:0] rx, input obs_t e);
    vec_t r;
    r.cs = cs; r.rv = rv; r.rx = rx; r.exp = e;
    return r;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.busy = bus.busy; o.err = bus.err; o.we = bus.csr_we; o.re = bus.csr_re;
    o.txl = bus.tx_load; o.addr = bus.csr_addr; o.wdata = bus.csr_wdata; o.txd = bus.tx_data;
    return o;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic cs, rv, input logic [7:0] rx);
    bus.spi_cs_act = cs;
    bus.rx_valid   = rv;
    bus.rx_data    = rx;
  endtask

  task automatic check_obs(input string name, input obs_t exp);
    obs_t got;
    got = sample();
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got busy=%0b err=%0b we=%0b re=%0b txl=%0b addr=%0d wdata=%h txd=%h | want busy=%0b err=%0b we=%0b re=%0b txl=%0b addr=%0d wdata=%h txd=%h",
               name, got.busy, got.err, got.we, got.re, got.txl, got.addr, got.wdata, got.txd,
               exp.busy, exp.err, exp.we, exp.re, exp.txl, exp.addr, exp.wdata, exp.txd);
    end
  endtask

  task automatic check_val(input string name, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  initial begin
    vec_t vec [NVEC];
    int   we0;
    int   re0;

    rst_bar   = 1'b0;
    rdata_src = 8'h3C;
    drive(1'b0, 1'b0, 8'h00);
    step();
    step();
    check_obs("reset", mk(0, 0, 0, 0, 0, 6'd0, 8'h00, 8'h00));
    rst_bar = 1'b1;

    // cs, rv, rx  -> outputs after the sampling edge
    vec[0]  = v(1, 1, 8'h9B, mk(1, 0, 0, 0, 0, 6'd0,       8'h00, 8'h00)); // WR 27 cmd
    vec[1]  = v(1, 1, 8'hA5, mk(0, 0, 1, 0, 0, CSR_PORTA,  8'hA5, 8'h00)); // data -> we
    vec[2]  = v(1, 0, 8'h00, mk(0, 0, 0, 0, 0, CSR_PORTA,  8'hA5, 8'h00));
    vec[3]  = v(1, 1, 8'h43, mk(1, 0, 0, 1, 0, CSR_PWM_HI, 8'hA5, 8'h00)); // RD 3
    vec[4]  = v(1, 0, 8'h00, mk(1, 0, 0, 0, 0, CSR_PWM_HI, 8'hA5, 8'h00));
    vec[5]  = v(1, 1, 8'hFF, mk(1, 0, 0, 0, 0, CSR_PWM_HI, 8'hA5, 8'h3C)); // byte ignored
    vec[6]  = v(1, 0, 8'h00, mk(0, 0, 0, 0, 1, CSR_PWM_HI, 8'hA5, 8'h3C)); // tx_load
    vec[7]  = v(1, 0, 8'h00, mk(0, 0, 0, 0, 0, CSR_PWM_HI, 8'hA5, 8'h3C));
    vec[8]  = v(1, 1, 8'hA5, mk(1, 1, 0, 0, 0, CSR_PWM_HI, 8'hA5, 8'h3C)); // WR 37
    vec[9]  = v(1, 1, 8'h77, mk(0, 1, 0, 0, 0, CSR_PWM_HI, 8'hA5, 8'h3C)); // discarded
    vec[10] = v(1, 1, 8'h00, mk(0, 0, 0, 0, 0, CSR_PWM_HI, 8'hA5, 8'h3C)); // NOP clears
    vec[11] = v(1, 1, 8'h60, mk(1, 1, 0, 0, 0, 6'd32,      8'hA5, 8'h3C)); // RD 32
    vec[12] = v(1, 0, 8'h00, mk(1, 1, 0, 0, 0, 6'd32,      8'hA5, 8'h3C));
    vec[13] = v(1, 0, 8'h00, mk(1, 1, 0, 0, 0, 6'd32,      8'hA5, 8'h00));
    vec[14] = v(1, 0, 8'h00, mk(0, 1, 0, 0, 1, 6'd32,      8'hA5, 8'h00));
    vec[15] = v(1, 1, 8'h9F, mk(1, 1, 0, 0, 0, 6'd32,      8'hA5, 8'h00)); // WR 31
    vec[16] = v(1, 1, 8'h5A, mk(0, 1, 1, 0, 0, 6'd31,      8'h5A, 8'h00));
    vec[17] = v(1, 1, 8'h3F, mk(0, 0, 0, 0, 0, 6'd31,      8'h5A, 8'h00)); // NOP
    vec[18] = v(1, 1, 8'h43, mk(1, 0, 0, 1, 0, CSR_PWM_HI, 8'h5A, 8'h00)); // RD 3
    vec[19] = v(0, 0, 8'h00, mk(0, 0, 0, 0, 0, CSR_PWM_HI, 8'h5A, 8'h00)); // abort
    vec[20] = v(1, 0, 8'h00, mk(0, 0, 0, 0, 0, CSR_PWM_HI, 8'h5A, 8'h00));
    vec[21] = v(1, 1, 8'h81, mk(1, 0, 0, 0, 0, CSR_PWM_HI, 8'h5A, 8'h00)); // WR 1
    vec[22] = v(0, 1, 8'h99, mk(0, 0, 0, 0, 0, CSR_PWM_HI, 8'h5A, 8'h00)); // abort wins
    vec[23] = v(1, 0, 8'h00, mk(0, 0, 0, 0, 0, CSR_PWM_HI, 8'h5A, 8'h00));
    vec[24] = v(0, 1, 8'h43, mk(0, 0, 0, 0, 0, CSR_PWM_HI, 8'h5A, 8'h00)); // cs low

    for (int i = 0; i < NVEC; i++) begin
      drive(vec[i].cs, vec[i].rv, vec[i].rx);
      step();
      check_obs($sformatf("vec%0d", i), vec[i].exp);
    end
    check_val("table_we_count", we_cnt, 2);
    check_val("table_re_count", re_cnt, 2);

    // Chip-select release during RESP cancels the pending tx_load
    rdata_src = 8'hC3;
    drive(1, 1, 8'h43); step();
    drive(1, 0, 8'h00); step();
    step();
    check_val("cancel_txd_captured", int'(bus.tx_data), 32'h0C3);
    drive(0, 0, 8'h00); step();
    check_val("cancel_txl", int'(bus.tx_load), 0);
    check_val("cancel_busy", int'(bus.busy), 0);
    drive(1, 0, 8'h00); step();
    check_val("cancel_txl_late", int'(bus.tx_load), 0);

    // No data byte within the window: timeout
    we0 = we_cnt;
    drive(1, 1, 8'h81); step();
    drive(1, 0, 8'h00);
    repeat (255) step();
    check_val("tmo_busy_at_255", int'(bus.busy), 1);
    step();
    check_val("tmo_busy_after", int'(bus.busy), 0);
    check_val("tmo_err", int'(bus.err), 1);
    check_val("tmo_no_we", we_cnt - we0, 0);
    drive(1, 1, 8'h00); step();
    drive(1, 0, 8'h00);
    check_val("nop_clears_err", int'(bus.err), 0);

    // Data byte on the last allowed cycle is accepted
    drive(1, 1, 8'h81); step();
    drive(1, 0, 8'h00);
    repeat (254) step();
    drive(1, 1, 8'h66); step();
    drive(1, 0, 8'h00);
    check_val("late_we", int'(bus.csr_we), 1);
    check_val("late_addr", int'(bus.csr_addr), 1);
    check_val("late_wdata", int'(bus.csr_wdata), 32'h066);
    check_val("late_err", int'(bus.err), 0);
    step();

    // Reset mid-operation: outputs clear at once, data byte never written
    we0 = we_cnt;
    drive(1, 1, 8'h81); step();
    drive(1, 1, 8'h5A);
    #2;
    rst_bar = 1'b0;
    #1;
    check_obs("rst_async", mk(0, 0, 0, 0, 0, 6'd0, 8'h00, 8'h00));
    step();
    rst_bar = 1'b1;
    drive(1, 0, 8'h00);
    step();
    check_val("rst_no_we", we_cnt - we0, 0);
    check_val("rst_idle", int'(bus.busy), 0);

    // Burst write from the last entry wraps to 0
    we0 = we_cnt;
    re0 = re_cnt;
    drive(1, 1, 8'hDF); step();
    drive(1, 1, 8'h11); step();
    drive(1, 1, 8'h22); step();
    drive(1, 0, 8'h00); step();
`ifdef CSR_SEQ_BURST_EN
    check_val("burst_busy", int'(bus.busy), 1);
    check_val("burst_we_count", we_cnt - we0, 2);
    check_val("burst_addr0", int'(wlog_addr[we0[2:0]]), 31);
    check_val("burst_data0", int'(wlog_data[we0[2:0]]), 32'h011);
    check_val("burst_addr1", int'(wlog_addr[3'(we0 + 1)]), 0);
    check_val("burst_data1", int'(wlog_data[3'(we0 + 1)]), 32'h022);
`else
    check_val("burst_off_busy", int'(bus.busy), 0);
    check_val("burst_off_we_count", we_cnt - we0, 0);
`endif
    check_val("burst_no_re", re_cnt - re0, 0);
    drive(0, 0, 8'h00); step();
    check_val("burst_end_busy", int'(bus.busy), 0);
    drive(1, 0, 8'h00); step();

    check_val("we_re_overlap", overlap_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
